// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants: default LCD geometry, shade intensities,
// line writer FSM encoding and the shade-to-intensity helper.
package gb_video_pkg;

  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;

  // Shade 0 is the lightest Game Boy colour, shade 3 the darkest.
  localparam logic [3:0] INTENSITY_SHADE0 = 4'hF;
  localparam logic [3:0] INTENSITY_SHADE1 = 4'hA;
  localparam logic [3:0] INTENSITY_SHADE2 = 4'h5;
  localparam logic [3:0] INTENSITY_SHADE3 = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } line_writer_state_t;

  function automatic logic [3:0] shade_to_intensity(input logic [1:0] shade);
    logic [3:0] result;
    case (shade)
      2'd0:    result = INTENSITY_SHADE0;
      2'd1:    result = INTENSITY_SHADE1;
      2'd2:    result = INTENSITY_SHADE2;
      default: result = INTENSITY_SHADE3;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/shade_lut.sv
// Combinational shade-to-intensity lookup. With LINE_WRITER_PALETTE_EN the
// shade is first remapped through the BGP palette register.
module shade_lut
  import gb_video_pkg::*;
(
  input  logic [1:0] shade_i,
`ifdef LINE_WRITER_PALETTE_EN
  input  logic [7:0] bgp_i,
`endif
  output logic [3:0] intensity_o
);

  logic [1:0] eff_shade;

`ifdef LINE_WRITER_PALETTE_EN
  // BGP holds four 2-bit fields; field s gives the displayed shade for s.
  always_comb eff_shade = bgp_i[{shade_i, 1'b0} +: 2];
`else
  always_comb eff_shade = shade_i;
`endif

  always_comb intensity_o = shade_to_intensity(eff_shade);

endmodule

// File: rtl/line_buffer_writer.sv
// Collects one PPU line of pixels into working bitplanes and commits them to
// the LineBuffer outputs with a one-cycle update pulse. Optional macro:
// LINE_WRITER_PALETTE_EN adds the bgp palette input.
module line_buffer_writer #(
  parameter int LCD_WIDTH  = gb_video_pkg::LCD_WIDTH,
  parameter int LCD_HEIGHT = gb_video_pkg::LCD_HEIGHT
) (
  input  logic                 pixelClk,
  input  logic                 reset,
  input  logic                 lineStart,
  input  logic [7:0]           lineLY,
  input  logic                 pixelValid,
  input  logic [1:0]           pixelShade,
`ifdef LINE_WRITER_PALETTE_EN
  input  logic [7:0]           bgp,
`endif
  output logic [LCD_WIDTH-1:0] LineBuffer0,
  output logic [LCD_WIDTH-1:0] LineBuffer1,
  output logic [LCD_WIDTH-1:0] LineBuffer2,
  output logic [LCD_WIDTH-1:0] LineBuffer3,
  output logic [7:0]           LY,
  output logic                 updateBufferSignal
);
  import gb_video_pkg::*;

  localparam int XW = (LCD_WIDTH > 1) ? $clog2(LCD_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LCD_WIDTH - 1);

  line_writer_state_t state_q, state_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [7:0]                    pend_q, pend_d;
  logic [7:0]                    ly_q;
  logic                          upd_q;
  logic [3:0][LCD_WIDTH-1:0]     plane_q, plane_d;
  logic [3:0][LCD_WIDTH-1:0]     lb_q;
  logic [3:0]                    intensity;
  logic                          start_ok;
  logic                          accept;
  logic [XW-1:0]                 wr_idx;

  shade_lut u_shade_lut (
    .shade_i     (pixelShade),
`ifdef LINE_WRITER_PALETTE_EN
    .bgp_i       (bgp),
`endif
    .intensity_o (intensity)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    pend_d   = pend_q;
    accept   = 1'b0;
    wr_idx   = x_q;
    start_ok = lineStart && (int'(lineLY) < LCD_HEIGHT);

    // lineStart is handled identically in every state: a FILL line is
    // abandoned, and the COMMIT cycle has already published its line.
    if (lineStart) begin
      if (start_ok) begin
        pend_d  = lineLY;
        state_d = FILL;
        x_d     = '0;
        wr_idx  = '0;
        accept  = pixelValid;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == FILL) begin
      accept = pixelValid;
    end else begin
      state_d = IDLE;
    end

    if (accept) begin
      if (wr_idx == X_LAST) begin
        state_d = COMMIT;
        x_d     = '0;
      end else begin
        x_d = wr_idx + XW'(1);
      end
    end
  end

  // Plane 0 carries intensity bit 3, plane 3 carries bit 0.
  always_comb begin
    plane_d = plane_q;
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        plane_d[k][wr_idx] = intensity[3-k];
      end
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      pend_q  <= '0;
      ly_q    <= '0;
      upd_q   <= 1'b0;
      plane_q <= '0;
      lb_q    <= '1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pend_q  <= pend_d;
      plane_q <= plane_d;
      upd_q   <= (state_d == COMMIT);
      // Outputs load on the edge entering COMMIT so they are valid with the pulse.
      if (state_d == COMMIT) begin
        lb_q <= plane_d;
        ly_q <= pend_d;
      end
    end
  end

  assign LineBuffer0        = lb_q[0];
  assign LineBuffer1        = lb_q[1];
  assign LineBuffer2        = lb_q[2];
  assign LineBuffer3        = lb_q[3];
  assign LY                 = ly_q;
  assign updateBufferSignal = upd_q;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Directed self-checking bench for line_buffer_writer (default 160x144 geometry).
module tb_line_buffer_writer;

  localparam int W = 160;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ALT  = {40{4'hA}};
  localparam logic [W-1:0] BIT0 = 160'h1;

  logic         pixelClk = 1'b0;
  logic         reset;
  logic         lineStart;
  logic [7:0]   lineLY;
  logic         pixelValid;
  logic [1:0]   pixelShade;
`ifdef LINE_WRITER_PALETTE_EN
  logic [7:0]   bgp;
`endif
  logic [W-1:0] LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3;
  logic [7:0]   LY;
  logic         updateBufferSignal;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  line_buffer_writer dut (
    .pixelClk           (pixelClk),
    .reset              (reset),
    .lineStart          (lineStart),
    .lineLY             (lineLY),
    .pixelValid         (pixelValid),
    .pixelShade         (pixelShade),
`ifdef LINE_WRITER_PALETTE_EN
    .bgp                (bgp),
`endif
    .LineBuffer0        (LineBuffer0),
    .LineBuffer1        (LineBuffer1),
    .LineBuffer2        (LineBuffer2),
    .LineBuffer3        (LineBuffer3),
    .LY                 (LY),
    .updateBufferSignal (updateBufferSignal)
  );

  // Clock and pulse monitor
  always #5 pixelClk = ~pixelClk;

  always @(negedge pixelClk) if (updateBufferSignal === 1'b1) pulses++;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  task automatic start_line(input logic [7:0] ly);
    lineStart  = 1'b1;
    lineLY     = ly;
    pixelValid = 1'b0;
    tick();
    lineStart  = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) begin
      pixelValid = 1'b1;
      pixelShade = s;
      tick();
    end
    pixelValid = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ONES}}) begin
      errors++; $display("FAIL reset_lb: got %h %h %h %h, want all ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    checks++; if (LY !== 8'd0) begin errors++; $display("FAIL reset_ly: got %0d want 0", LY); end
    checks++; if (updateBufferSignal !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", updateBufferSignal); end
  endtask

  task automatic test_white_line();
    int p0;
    p0 = pulses;
    start_line(8'd5);
    send_pixels(159, 2'd0);
    checks++; if (updateBufferSignal !== 1'b0) begin errors++; $display("FAIL white_early_upd: got %b want 0", updateBufferSignal); end
    send_pixels(1, 2'd0);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL white_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd5) begin errors++; $display("FAIL white_ly: got %0d want 5", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ONES}}) begin
      errors++; $display("FAIL white_lb: got %h %h %h %h, want all ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
    checks++; if (updateBufferSignal !== 1'b0) begin errors++; $display("FAIL white_pulse_len: got %b want 0", updateBufferSignal); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL white_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_alternate();
    start_line(8'd7);
    for (int i = 0; i < W; i++) begin
      pixelValid = 1'b1;
      pixelShade = (i % 2 == 0) ? 2'd3 : 2'd1;
      tick();
    end
    pixelValid = 1'b0;
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL alt_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd7) begin errors++; $display("FAIL alt_ly: got %0d want 7", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {ALT, ZERO, ALT, ZERO}) begin
      errors++; $display("FAIL alt_lb: got %h %h %h %h, want %h 0 %h 0", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3, ALT, ALT); end
    tick();
  endtask

  task automatic test_shade2();
    start_line(8'd8);
    send_pixels(160, 2'd2);
    checks++; if (LY !== 8'd8) begin errors++; $display("FAIL shade2_ly: got %0d want 8", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {ZERO, ONES, ZERO, ONES}) begin
      errors++; $display("FAIL shade2_lb: got %h %h %h %h, want 0 ones 0 ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
  endtask

  task automatic test_abandon();
    int p0;
    p0 = pulses;
    start_line(8'd10);
    send_pixels(80, 2'd3);
    start_line(8'd11);
    send_pixels(160, 2'd0);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL abandon_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd11) begin errors++; $display("FAIL abandon_ly: got %0d want 11", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ONES}}) begin
      errors++; $display("FAIL abandon_lb: got %h %h %h %h, want all ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL abandon_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_ignored_lines();
    int p0;
    p0 = pulses;
    send_pixels(20, 2'd3);
    start_line(8'd150);
    send_pixels(160, 2'd3);
    start_line(8'd144);
    send_pixels(160, 2'd3);
    tick();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL ignored_pulses: got %0d want 0", pulses - p0); end
    checks++; if (LY !== 8'd11) begin errors++; $display("FAIL ignored_ly: got %0d want 11", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ONES}}) begin
      errors++; $display("FAIL ignored_lb: got %h %h %h %h, want all ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
  endtask

  task automatic test_last_visible();
    start_line(8'd143);
    send_pixels(160, 2'd3);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL last_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd143) begin errors++; $display("FAIL last_ly: got %0d want 143", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ZERO}}) begin
      errors++; $display("FAIL last_lb: got %h %h %h %h, want all zeros", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
  endtask

  task automatic test_same_cycle();
    lineStart  = 1'b1;
    lineLY     = 8'd20;
    pixelValid = 1'b1;
    pixelShade = 2'd3;
    tick();
    lineStart  = 1'b0;
    send_pixels(158, 2'd0);
    checks++; if (updateBufferSignal !== 1'b0) begin errors++; $display("FAIL same_early_upd: got %b want 0", updateBufferSignal); end
    send_pixels(1, 2'd0);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL same_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd20) begin errors++; $display("FAIL same_ly: got %0d want 20", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{~BIT0}}) begin
      errors++; $display("FAIL same_lb: got %h %h %h %h, want %h x4", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3, ~BIT0); end
    tick();
  endtask

  task automatic test_commit_restart();
    int p0;
    p0 = pulses;
    start_line(8'd40);
    send_pixels(160, 2'd3);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL restart_first_upd: got %b want 1", updateBufferSignal); end
    start_line(8'd41);
    checks++; if (LY !== 8'd40) begin errors++; $display("FAIL restart_first_ly: got %0d want 40", LY); end
    send_pixels(160, 2'd2);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL restart_second_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd41) begin errors++; $display("FAIL restart_second_ly: got %0d want 41", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {ZERO, ONES, ZERO, ONES}) begin
      errors++; $display("FAIL restart_lb: got %h %h %h %h, want 0 ones 0 ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL restart_pulses: got %0d want 2", pulses - p0); end
  endtask

  task automatic test_reset_mid_fill();
    int p0;
    start_line(8'd3);
    send_pixels(100, 2'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0 = pulses;
    send_pixels(60, 2'd3);
    tick();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", pulses - p0); end
    checks++; if (LY !== 8'd0) begin errors++; $display("FAIL rstmid_ly: got %0d want 0", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ONES}}) begin
      errors++; $display("FAIL rstmid_lb: got %h %h %h %h, want all ones", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
  endtask

`ifdef LINE_WRITER_PALETTE_EN
  task automatic test_palette();
    bgp = 8'h1B;
    start_line(8'd9);
    send_pixels(160, 2'd0);
    checks++; if (updateBufferSignal !== 1'b1) begin errors++; $display("FAIL pal_upd: got %b want 1", updateBufferSignal); end
    checks++; if (LY !== 8'd9) begin errors++; $display("FAIL pal_ly: got %0d want 9", LY); end
    checks++; if ({LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3} !== {4{ZERO}}) begin
      errors++; $display("FAIL pal_lb: got %h %h %h %h, want all zeros", LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3); end
    tick();
    bgp = 8'hE4;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    lineStart  = 1'b0;
    lineLY     = 8'd0;
    pixelValid = 1'b0;
    pixelShade = 2'd0;
`ifdef LINE_WRITER_PALETTE_EN
    bgp        = 8'hE4;
`endif
    test_reset();
    test_white_line();
    test_alternate();
    test_shade2();
    test_abandon();
    test_ignored_lines();
    test_last_visible();
    test_same_cycle();
    test_commit_restart();
    test_reset_mid_fill();
`ifdef LINE_WRITER_PALETTE_EN
    test_palette();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
